wo_reg_access_ctrl: RTL and testbench

Upstream access controller for a bank of write-once registers. It accepts single register transactions over a valid/ready request channel, decodes the address, and issues a one-cycle write strobe plus write data to the addressed register. It reads back register contents and lock status, and returns a response with read data and an error flag on a valid/ready response channel. It sits between the block's bus front end and the write-once register instances.

---
 rtl/wo_reg_access_ctrl.sv | 173 +++++++++++++++++
 tb/tb_wo_reg_access_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wo_reg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wo_reg_access_ctrl
// Description : Upstream access controller for a bank of write-once registers.
//               Accepts one register transaction at a time over a valid/ready
//               request channel, decodes the address, issues a one-cycle
//               write strobe, reads back register contents, and returns
//               read data plus an error flag over a valid/ready response
//               channel. Keeps a saturating count of errored transactions.
// Ports       :
//   Clk         in   clock, rising edge
//   ip_resetn   in   asynchronous active-low reset
//   req_valid   in   request valid
//   req_ready   out  request accepted when high together with req_valid
//   req_write   in   1 = write, 0 = read
//   req_addr    in   [ADDR_W]   register index
//   req_wdata   in   [DATA_W]   write data
//   rsp_valid   out  response valid
//   rsp_ready   in   response consumed when high together with rsp_valid
//   rsp_rdata   out  [DATA_W]   read data or post-write readback
//   rsp_err     out  decode or lock error
//   reg_write   out  [NUM_REGS] one-hot write strobe
//   reg_wdata   out  [DATA_W]   write data to the registers
//   reg_rdata   in   [NUM_REGS*DATA_W] register i at [i*DATA_W +: DATA_W]
//   reg_locked  in   [NUM_REGS] per-register lock status
//   err_count   out  [ERRCNT_W] saturating errored-transaction count
// Revision    : 1.0 - initial release
// ============================================================================
module wo_reg_access_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic                       Clk,
  input  logic                       ip_resetn,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [NUM_REGS-1:0]        reg_write,
  output logic [DATA_W-1:0]          reg_wdata,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata,
  input  logic [NUM_REGS-1:0]        reg_locked,
  output logic [ERRCNT_W-1:0]        err_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WSTROBE = 3'd1,
    S_WSETTLE = 3'd2,
    S_RSAMPLE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [NUM_REGS-1:0] r_reg_write;
  logic [DATA_W-1:0]   r_reg_wdata;
  logic [ERRCNT_W-1:0] r_err_count;

  logic [DATA_W-1:0]   w_req_rdata;
  logic [DATA_W-1:0]   w_cap_rdata;
  logic                w_req_locked;
  logic                w_req_in_range;
  logic                w_err_sat;

  // Address decode by explicit compare against each implemented index, so an
  // out-of-range address (when 2**ADDR_W > NUM_REGS) never indexes past the
  // end of the concatenated read bus and simply flags "not in range".
  always_comb begin
    w_req_rdata    = '0;
    w_cap_rdata    = '0;
    w_req_locked   = 1'b0;
    w_req_in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (req_addr == ADDR_W'(i)) begin
        w_req_rdata    = reg_rdata[i*DATA_W +: DATA_W];
        w_req_locked   = reg_locked[i];
        w_req_in_range = 1'b1;
      end
      if (r_addr == ADDR_W'(i)) begin
        w_cap_rdata = reg_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_err_sat = &r_err_count;

  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_reg_write <= '0;
      r_reg_wdata <= '0;
      r_err_count <= '0;
    end else begin
      // Strobe is a single-cycle pulse; it is only set on the accept edge.
      r_reg_write <= '0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            if (!w_req_in_range) begin
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
              if (!w_err_sat) r_err_count <= r_err_count + 1'b1;
            end else if (req_write && w_req_locked) begin
              // Lock is judged only here, at accept time.
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= w_req_rdata;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
              if (!w_err_sat) r_err_count <= r_err_count + 1'b1;
            end else if (req_write) begin
              r_reg_write <= NUM_REGS'(1) << req_addr;
              r_reg_wdata <= req_wdata;
              r_state     <= S_WSTROBE;
            end else begin
              r_state <= S_RSAMPLE;
            end
          end
        end
        S_WSTROBE: begin
          r_state <= S_WSETTLE;
        end
        S_WSETTLE, S_RSAMPLE: begin
          r_rsp_rdata <= w_cap_rdata;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign reg_write = r_reg_write;
  assign reg_wdata = r_reg_wdata;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_wo_reg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wo_reg_access_ctrl
// Description : Directed self-checking bench for wo_reg_access_ctrl with
//               three registers behind a 2-bit address, so address 3 is an
//               undecoded location. A small register model stores written
//               data with bit0 cleared and locks itself when bit0 was set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wo_reg_access_ctrl;

  localparam int NUM_REGS = 3;
  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 16;
  localparam int ERRCNT_W = 8;

  logic                       Clk = 1'b0;
  logic                       ip_resetn;
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [ADDR_W-1:0]          req_addr;
  logic [DATA_W-1:0]          req_wdata;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_W-1:0]          rsp_rdata;
  logic                       rsp_err;
  logic [NUM_REGS-1:0]        reg_write;
  logic [DATA_W-1:0]          reg_wdata;
  logic [NUM_REGS*DATA_W-1:0] reg_rdata;
  logic [NUM_REGS-1:0]        reg_locked;
  logic [ERRCNT_W-1:0]        err_count;

  int n_cmp = 0;
  int n_mis = 0;

  // Register model: preset values from the stimulus, overridden by writes.
  logic [DATA_W-1:0]   m_init_val [NUM_REGS];
  logic [NUM_REGS-1:0] m_init_lock;
  logic [DATA_W-1:0]   m_wr_val   [NUM_REGS];
  logic [NUM_REGS-1:0] m_wr      = '0;
  logic [NUM_REGS-1:0] m_wr_lock = '0;

  always @(posedge Clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_write[i]) begin
        m_wr[i]      <= 1'b1;
        m_wr_val[i]  <= reg_wdata & 16'hFFFE;
        m_wr_lock[i] <= reg_wdata[0];
      end
    end
  end

  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_rdata[i*DATA_W +: DATA_W] = m_wr[i] ? m_wr_val[i] : m_init_val[i];
  end
  assign reg_locked = m_init_lock | m_wr_lock;

  wo_reg_access_ctrl #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERRCNT_W(ERRCNT_W)
  ) dut (
    .Clk(Clk), .ip_resetn(ip_resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .reg_write(reg_write), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_locked(reg_locked), .err_count(err_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for exactly one edge (the accept edge), then drop it.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    ip_resetn = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    m_init_val[0] = 16'h1234;
    m_init_val[1] = 16'h0000;
    m_init_val[2] = 16'hBEEF;
    m_init_lock   = 3'b100;

    // ---- Reset state
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    ip_resetn = 1'b1;
    tick();
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // ---- Read addr 0: response one edge after accept
    issue(1'b0, 2'd0, 16'h0);
    chk("rd0_strobe_c1", 32'(reg_write), 32'd0);
    chk("rd0_valid_c1", 32'(rsp_valid), 32'd0);
    chk("rd0_ready_busy", 32'(req_ready), 32'd0);
    tick();
    chk("rd0_valid_c2", 32'(rsp_valid), 32'd1);
    chk("rd0_rdata", 32'(rsp_rdata), 32'h1234);
    chk("rd0_err", 32'(rsp_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd0_valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("rd0_ready_after_hs", 32'(req_ready), 32'd1);

    // ---- Write addr 1 A5A5 (model stores A5A4 and locks), then backpressure
    issue(1'b1, 2'd1, 16'hA5A5);
    chk("wr1_strobe_c1", 32'(reg_write), 32'b010);
    chk("wr1_wdata", 32'(reg_wdata), 32'hA5A5);
    chk("wr1_valid_c1", 32'(rsp_valid), 32'd0);
    tick();
    chk("wr1_strobe_c2", 32'(reg_write), 32'd0);
    chk("wr1_valid_c2", 32'(rsp_valid), 32'd0);
    chk("wr1_wdata_hold", 32'(reg_wdata), 32'hA5A5);
    tick();
    chk("wr1_valid_c3", 32'(rsp_valid), 32'd1);
    chk("wr1_rdata", 32'(rsp_rdata), 32'hA5A4);
    chk("wr1_err", 32'(rsp_err), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", 32'(rsp_rdata), 32'hA5A4);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold_valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("hold_ready_after_hs", 32'(req_ready), 32'd1);

    // ---- Read addr 2 with rsp_ready asserted early
    rsp_ready = 1'b1;
    issue(1'b0, 2'd2, 16'h0);
    chk("early_rdy_valid_c1", 32'(rsp_valid), 32'd0);
    tick();
    chk("early_rdy_valid_c2", 32'(rsp_valid), 32'd1);
    chk("early_rdy_rdata", 32'(rsp_rdata), 32'hBEEF);
    tick();
    rsp_ready = 1'b0;
    chk("early_rdy_valid_done", 32'(rsp_valid), 32'd0);
    chk("early_rdy_ready_back", 32'(req_ready), 32'd1);

    // ---- Write to preset-locked addr 2: immediate error, no strobe
    issue(1'b1, 2'd2, 16'h0F0F);
    chk("lk2_strobe", 32'(reg_write), 32'd0);
    chk("lk2_valid_c1", 32'(rsp_valid), 32'd1);
    chk("lk2_err", 32'(rsp_err), 32'd1);
    chk("lk2_rdata", 32'(rsp_rdata), 32'hBEEF);
    chk("lk2_err_count", 32'(err_count), 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("lk2_model_untouched", 32'(m_wr[2]), 32'd0);

    // ---- Second write to addr 1, which locked itself on the first write
    issue(1'b1, 2'd1, 16'h1111);
    chk("lk1_strobe", 32'(reg_write), 32'd0);
    chk("lk1_err", 32'(rsp_err), 32'd1);
    chk("lk1_rdata", 32'(rsp_rdata), 32'hA5A4);
    chk("lk1_err_count", 32'(err_count), 32'd2);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- Undecoded address 3
    issue(1'b1, 2'd3, 16'hFFFF);
    chk("a3_strobe", 32'(reg_write), 32'd0);
    chk("a3_valid", 32'(rsp_valid), 32'd1);
    chk("a3_err", 32'(rsp_err), 32'd1);
    chk("a3_rdata", 32'(rsp_rdata), 32'd0);
    chk("a3_err_count", 32'(err_count), 32'd3);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // ---- Reset asserted mid-strobe on a write to addr 0
    issue(1'b1, 2'd0, 16'h0002);
    chk("rw_strobe_pre", 32'(reg_write), 32'b001);
    #2;
    ip_resetn = 1'b0;
    #1;
    chk("rw_strobe_drop", 32'(reg_write), 32'd0);
    chk("rw_wdata_zero", 32'(reg_wdata), 32'd0);
    chk("rw_valid_zero", 32'(rsp_valid), 32'd0);
    chk("rw_ready_zero", 32'(req_ready), 32'd0);
    chk("rw_errcnt_zero", 32'(err_count), 32'd0);
    tick();
    chk("rw_no_reg_write", 32'(m_wr[0]), 32'd0);
    ip_resetn = 1'b1;
    tick();
    chk("rw_no_response", 32'(rsp_valid), 32'd0);
    chk("rw_ready_back", 32'(req_ready), 32'd1);

    // ---- 300 back-to-back errored accesses: two edges per transaction
    req_write = 1'b0;
    req_addr  = 2'd3;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    repeat (200) tick();
    chk("sat_count_100", 32'(err_count), 32'd100);
    repeat (400) tick();
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("sat_count_255", 32'(err_count), 32'd255);
    tick();
    chk("sat_count_hold", 32'(err_count), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
